// File: rtl/onehot_decoder_seq.sv
// Registered one-hot decoder with an ascending sweep mode (IDLE -> SWEEP -> DONE).
// Optional macro DEC_HOLD_EN: in IDLE with en=0, out/valid hold instead of clearing.
module onehot_decoder_seq #(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned LAST  = 2**SEL_W - 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  sweep_start,
    output logic [2**SEL_W-1:0]   out,
    output logic                  valid,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned      OUT_W    = 2**SEL_W;
    localparam logic [OUT_W-1:0] ONE      = OUT_W'(1);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(LAST);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   out_d;
    logic               valid_d, busy_d, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out;
        valid_d = valid;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            SWEEP: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    out_d   = '0;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + SEL_W'(1);
                    out_d   = ONE << cnt_d;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            // DONE lasts one cycle and then decodes its inputs exactly like IDLE.
            default: begin
                state_d = IDLE;
                if (sweep_start) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                    out_d   = ONE;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (en) begin
                    out_d   = ONE << sel;
                    valid_d = 1'b1;
                end else begin
`ifdef DEC_HOLD_EN
                    out_d   = out;
                    valid_d = valid;
`else
                    out_d   = '0;
                    valid_d = 1'b0;
`endif
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out     <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out     <= out_d;
            valid   <= valid_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Scoreboard bench for onehot_decoder_seq: three instances (LAST=7, LAST=0, SEL_W=4).
// Driver pushes expected outputs; a monitor pops and compares one cycle later.
module tb_onehot_decoder_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       en_a, ss_a;
    logic [2:0] sel_a;
    logic [7:0] out_a;
    logic       valid_a, busy_a, done_a;

    logic       en_z, ss_z;
    logic [2:0] sel_z;
    logic [7:0] out_z;
    logic       valid_z, busy_z, done_z;

    logic       en_w, ss_w;
    logic [3:0] sel_w;
    logic [15:0] out_w;
    logic       valid_w, busy_w, done_w;

    onehot_decoder_seq #(.SEL_W(3), .LAST(7)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .sel(sel_a), .sweep_start(ss_a),
        .out(out_a), .valid(valid_a), .busy(busy_a), .done(done_a));

    onehot_decoder_seq #(.SEL_W(3), .LAST(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .en(en_z), .sel(sel_z), .sweep_start(ss_z),
        .out(out_z), .valid(valid_z), .busy(busy_z), .done(done_z));

    onehot_decoder_seq #(.SEL_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .en(en_w), .sel(sel_w), .sweep_start(ss_w),
        .out(out_w), .valid(valid_w), .busy(busy_w), .done(done_w));

    typedef struct {
        int          id;
        logic [15:0] out;
        logic        valid;
        logic        busy;
        logic        done;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

`ifdef DEC_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got out/valid/busy/done=%h required %h", name, act, exp);
        else
            passed++;
    endtask

    function automatic logic [18:0] pack_dut(input int id);
        case (id)
            0:       return {8'h00, out_a, valid_a, busy_a, done_a};
            1:       return {8'h00, out_z, valid_z, busy_z, done_z};
            default: return {out_w, valid_w, busy_w, done_w};
        endcase
    endfunction

    // Monitor: consumes one expectation per rising edge, sampled just after it.
    always begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check(e.name, pack_dut(e.id), {e.out, e.valid, e.busy, e.done});
        end
    end

    task automatic step(input int id, input bit en, input int sel, input bit ss,
                        input logic [15:0] eo, input bit ev, input bit eb, input bit ed,
                        input string name);
        exp_t e;
        @(negedge clk);
        en_a = 1'b0; sel_a = '0; ss_a = 1'b0;
        en_z = 1'b0; sel_z = '0; ss_z = 1'b0;
        en_w = 1'b0; sel_w = '0; ss_w = 1'b0;
        case (id)
            0:       begin en_a = en; sel_a = 3'(sel); ss_a = ss; end
            1:       begin en_z = en; sel_z = 3'(sel); ss_z = ss; end
            default: begin en_w = en; sel_w = 4'(sel); ss_w = ss; end
        endcase
        e.id = id; e.out = eo; e.valid = ev; e.busy = eb; e.done = ed; e.name = name;
        sb.push_back(e);
    endtask

    task automatic run_sweep_a(input logic [15:0] done_from);
        // Indices 1..7 follow the start cycle; en/sel toggle and must be ignored.
        for (int i = 1; i < 8; i++)
            step(0, i[0], 7 - i, 1'b0, 16'(1) << i, 1'b1, 1'b1, 1'b0, $sformatf("sweep_idx%0d", i));
        step(0, 1'b1, 6, 1'b0, done_from, 1'b0, 1'b0, 1'b1, "sweep_done");
    endtask

    initial begin
        en_a = 0; sel_a = 0; ss_a = 0;
        en_z = 0; sel_z = 0; ss_z = 0;
        en_w = 0; sel_w = 0; ss_w = 0;

        #1;
        check("reset_a", pack_dut(0), 19'h0);
        check("reset_w", pack_dut(2), 19'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Direct decode, then idle behaviour.
        step(0, 1'b1, 5, 1'b0, 16'h0020, 1'b1, 1'b0, 1'b0, "decode_sel5");
        step(0, 1'b0, 0, 1'b0, HOLD ? 16'h0020 : 16'h0, HOLD, 1'b0, 1'b0, "idle_after_sel5");
        step(0, 1'b1, 2, 1'b0, 16'h0004, 1'b1, 1'b0, 1'b0, "decode_sel2");
        step(0, 1'b1, 7, 1'b0, 16'h0080, 1'b1, 1'b0, 1'b0, "decode_sel7");
        step(0, 1'b1, 0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, "decode_sel0");
        step(0, 1'b0, 0, 1'b0, HOLD ? 16'h0001 : 16'h0, HOLD, 1'b0, 1'b0, "idle_after_sel0");

        // Sweep started together with en=1/sel=3: sweep wins.
        step(0, 1'b1, 3, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, "sweep_start_over_en");
        run_sweep_a(16'h0);
        step(0, 1'b0, 0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, "idle_after_done");

        // Asynchronous abort at index 4.
        step(0, 1'b0, 0, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, "abort_idx0");
        for (int i = 1; i <= 4; i++)
            step(0, 1'b0, 0, 1'b0, 16'(1) << i, 1'b1, 1'b1, 1'b0, $sformatf("abort_idx%0d", i));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", pack_dut(0), 19'h0);
        @(posedge clk);
        #1;
        check("in_reset_no_done", pack_dut(0), 19'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1'b0, 0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, "idle_after_release");
        step(0, 1'b0, 0, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, "restart_idx0");
        run_sweep_a(16'h0);

        // LAST=0 with sweep_start held high.
        step(1, 1'b0, 0, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, "last0_valid");
        step(1, 1'b0, 0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, "last0_done");
        step(1, 1'b0, 0, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, "last0_retrigger");
        step(1, 1'b0, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, "last0_done2");
        step(1, 1'b0, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, "last0_idle");

        // SEL_W=4 walk.
        for (int s = 0; s < 16; s++)
            step(2, 1'b1, s, 1'b0, 16'(1) << s, 1'b1, 1'b0, 1'b0, $sformatf("w16_sel%0d", s));
        step(2, 1'b0, 0, 1'b0, HOLD ? 16'h8000 : 16'h0, HOLD, 1'b0, 1'b0, "w16_idle");

        @(negedge clk);
        en_a = 0; ss_a = 0; en_z = 0; ss_z = 0; en_w = 0; ss_w = 0;
        for (int t = 0; t < 10 && sb.size() > 0; t++)
            @(negedge clk);
        total++;
        if (sb.size() != 0)
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        else
            passed++;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
